// File: rtl/mmio_slot_fabric.sv
// mmio_slot_fabric: FPro MMIO slot decoder with a posted-write FIFO and ordered ready/valid reads
// Ports:
//   clk, reset                 system clock, asynchronous active-low reset
//   mmio_cs/wr/rd/addr/wr_data bus request, held by the host until mmio_ready accepts it
//   mmio_ready                 request accepted this cycle when high
//   mmio_rd_data/rd_valid      registered read data and its one-cycle valid pulse
//   slot_cs/mem_rd/mem_wr_array one-hot per-slot select and strobes
//   slot_reg_addr/wr_data      shared register address and write data
//   slot_rd_data_flat          slot i read data at bits [32*i+31:32*i]
// Optional macro MMIO_ERR_CAPTURE_EN adds err_clr, err_flag and err_addr (first unmapped access).
module mmio_slot_fabric #(
  parameter int NUM_SLOTS  = 64,
  parameter int SLOT_BITS  = 6,
  parameter int REG_BITS   = 5,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mmio_cs,
  input  logic                    mmio_wr,
  input  logic                    mmio_rd,
  input  logic [20:0]             mmio_addr,
  input  logic [31:0]             mmio_wr_data,
  output logic                    mmio_ready,
  output logic [31:0]             mmio_rd_data,
  output logic                    mmio_rd_valid,
  output logic [NUM_SLOTS-1:0]    slot_cs_array,
  output logic [NUM_SLOTS-1:0]    slot_mem_rd_array,
  output logic [NUM_SLOTS-1:0]    slot_mem_wr_array,
  output logic [REG_BITS-1:0]     slot_reg_addr,
  output logic [31:0]             slot_wr_data,
  input  logic [32*NUM_SLOTS-1:0] slot_rd_data_flat
`ifdef MMIO_ERR_CAPTURE_EN
  ,
  input  logic                    err_clr,
  output logic                    err_flag,
  output logic [20:0]             err_addr
`endif
);
  localparam int AW = REG_BITS + SLOT_BITS;
  localparam int EW = AW + 32;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int NS = 2 ** SLOT_BITS;
  localparam logic [NUM_SLOTS-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, RESP} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem_q [WBUF_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [NS-1:0] map;
  logic [31:0] rd_mux [NS];
  logic accept, push, rd_acc, pop, issue, full, wr_hit, rd_hit;
  logic [EW-1:0] head;
  logic [SLOT_BITS-1:0] h_slot, r_slot;
  logic unused_ok;
  // Pad the slot space to 2**SLOT_BITS so unmapped indices decode to "no slot" and read as zero.
  for (genvar i = 0; i < NS; i++) begin : g_slot
    if (i < NUM_SLOTS) begin : g_m
      assign map[i] = 1'b1;
      assign rd_mux[i] = slot_rd_data_flat[32*i +: 32];
    end else begin : g_u
      assign map[i] = 1'b0;
      assign rd_mux[i] = '0;
    end
  end
  assign unused_ok = ^mmio_addr[20:AW];
  assign full = cnt_q == (PW+1)'(WBUF_DEPTH);
  assign mmio_ready = (state_q == IDLE) & ~full;
  assign accept = mmio_cs & (mmio_wr | mmio_rd) & mmio_ready;
  assign push = accept & mmio_wr;
  assign rd_acc = accept & ~mmio_wr;
  assign issue = state_q == ISSUE;
  // The FIFO head drains every cycle except the read issue cycle, keeping strobes exclusive.
  assign pop = (cnt_q != '0) & ~issue;
  assign head = mem_q[rp_q];
  assign h_slot = head[EW-1 -: SLOT_BITS];
  assign r_slot = rd_addr_q[AW-1:REG_BITS];
  assign wr_hit = pop & map[h_slot];
  assign rd_hit = issue & map[r_slot];
  assign slot_mem_wr_array = wr_hit ? ONE << h_slot : '0;
  assign slot_mem_rd_array = rd_hit ? ONE << r_slot : '0;
  assign slot_cs_array = slot_mem_wr_array | slot_mem_rd_array;
  assign slot_reg_addr = issue ? rd_addr_q[REG_BITS-1:0] : head[32 +: REG_BITS];
  assign slot_wr_data = head[31:0];
  assign mmio_rd_valid = state_q == RESP;
  assign mmio_rd_data = rd_data_q;
  always_comb begin
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    rd_addr_d = rd_acc ? mmio_addr[AW-1:0] : rd_addr_q;
    rd_data_d = issue ? rd_mux[r_slot] : rd_data_q;
    state_d = state_q == IDLE  ? (rd_acc ? (cnt_d != '0 ? DRAIN : ISSUE) : IDLE) :
              state_q == DRAIN ? (cnt_d == '0 ? ISSUE : DRAIN) :
              state_q == ISSUE ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_q + PW'(push);
      rp_q <= rp_q + PW'(pop);
      cnt_q <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {mmio_addr[AW-1:0], mmio_wr_data};
  end
`ifdef MMIO_ERR_CAPTURE_EN
  logic err_flag_q, err_flag_d, take;
  logic [20:0] err_addr_q, err_addr_d;
  // A new error is captured when none is held, or when it coincides with a clear.
  assign take = accept & ~map[mmio_addr[AW-1:REG_BITS]] & (~err_flag_q | err_clr);
  assign err_flag_d = take | (err_flag_q & ~err_clr);
  assign err_addr_d = take ? mmio_addr : err_clr ? '0 : err_addr_q;
  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end
`endif
endmodule

// File: tb/tb_mmio_slot_fabric.sv
// tb_mmio_slot_fabric: directed self-checking bench for mmio_slot_fabric with NUM_SLOTS=14
module tb_mmio_slot_fabric;
  localparam int N = 14;
  logic clk = 0, reset = 0, mmio_cs = 0, mmio_wr = 0, mmio_rd = 0;
  logic [20:0] mmio_addr = '0;
  logic [31:0] mmio_wr_data = '0;
  logic mmio_ready, mmio_rd_valid;
  logic [31:0] mmio_rd_data, slot_wr_data;
  logic [N-1:0] slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
  logic [4:0] slot_reg_addr;
  logic [32*N-1:0] slot_rd_data_flat;
  logic err_clr = 0, err_flag;
  logic [20:0] err_addr;
  int checks = 0, errors = 0, cyc = 0, bad = 0, rdy_low = 0;
  int rd_cnt = 0, rd_cyc = -1, rd_slot = -1, valid_cnt = 0, valid_cyc = -1;
  logic [31:0] valid_data;
  typedef struct {int slot; int rg; logic [31:0] d; int c;} wev_t;
  wev_t wlog[$];
  mmio_slot_fabric #(.NUM_SLOTS(N), .SLOT_BITS(6), .REG_BITS(5), .WBUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_ready(mmio_ready),
    .mmio_rd_data(mmio_rd_data), .mmio_rd_valid(mmio_rd_valid), .slot_cs_array(slot_cs_array),
    .slot_mem_rd_array(slot_mem_rd_array), .slot_mem_wr_array(slot_mem_wr_array),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data), .slot_rd_data_flat(slot_rd_data_flat)
`ifdef MMIO_ERR_CAPTURE_EN
    , .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Cycle k is the window between edge k-1 and edge k, so a negedge sample belongs to cycle cyc+1.
  always @(negedge clk) begin
    if ($countones(slot_mem_wr_array) + $countones(slot_mem_rd_array) > 1) bad++;
    if (slot_cs_array != (slot_mem_wr_array | slot_mem_rd_array)) bad++;
    for (int i = 0; i < N; i++) begin
      if (slot_mem_wr_array[i]) wlog.push_back('{i, int'(slot_reg_addr), slot_wr_data, cyc + 1});
      if (slot_mem_rd_array[i]) begin
        rd_cnt++;
        rd_cyc = cyc + 1;
        rd_slot = i;
      end
    end
    if (mmio_rd_valid) begin
      valid_cnt++;
      valid_cyc = cyc + 1;
      valid_data = mmio_rd_data;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic do_acc(input logic w, input logic r, input logic [20:0] a, input logic [31:0] d, output int t);
    logic rdy;
    mmio_cs = 1; mmio_wr = w; mmio_rd = r; mmio_addr = a; mmio_wr_data = d; t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      rdy = mmio_ready;
      if (!rdy) rdy_low++;
      @(posedge clk);
      #1;
      if (rdy) t = cyc;
    end
    if (t < 0) check("acc_timeout", 0, 1);
    mmio_cs = 0; mmio_wr = 0; mmio_rd = 0;
  endtask
  task automatic idle_check(input string tag);
    check({tag, "_ready"}, mmio_ready, 1);
    check({tag, "_rd_data"}, mmio_rd_data, 0);
    check({tag, "_valid"}, mmio_rd_valid, 0);
    check({tag, "_strobes"}, {slot_cs_array, slot_mem_rd_array, slot_mem_wr_array}, 0);
  endtask
  initial begin
    int t, t0, v0, r0, l0;
    for (int i = 0; i < N; i++) slot_rd_data_flat[32*i +: 32] = 32'hD000_0000 | i;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    idle_check("rst_init");
    // single write to slot 2 reg 3
    @(posedge clk); #1;
    wlog.delete();
    do_acc(1, 0, 21'h43, 32'hA5A5_0001, t);
    repeat (3) @(negedge clk);
    check("w1_count", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("w1_slot", wlog[0].slot, 2);
      check("w1_reg", wlog[0].rg, 3);
      check("w1_data", wlog[0].d, 32'hA5A5_0001);
      check("w1_cycle", wlog[0].c, t + 1);
    end
    // five back-to-back writes to slots 6..10
    @(posedge clk); #1;
    wlog.delete();
    l0 = rdy_low;
    for (int i = 0; i < 5; i++) begin
      do_acc(1, 0, 21'((6 + i) * 32 + i), 32'h1000_0000 + i, t);
      if (i == 0) t0 = t;
    end
    check("b2b_span", t - t0, 4);
    check("b2b_ready_low", rdy_low - l0, 0);
    repeat (4) @(negedge clk);
    check("b2b_count", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      check("b2b_slot", wlog[i].slot, 6 + i);
      check("b2b_data", wlog[i].d, 32'h1000_0000 + i);
    end
    // three writes to slot 5 then a read of slot 5
    @(posedge clk); #1;
    wlog.delete();
    v0 = valid_cnt; r0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      do_acc(1, 0, 21'hA0 + 21'(i), 32'h5500_0000 + i, t);
      if (i == 0) t0 = t;
    end
    do_acc(0, 1, 21'hA7, 32'h0, t);
    check("rw_rd_edge", t, t0 + 3);
    repeat (6) @(negedge clk);
    check("rw_wcount", wlog.size(), 3);
    check("rw_rd_count", rd_cnt - r0, 1);
    check("rw_rd_slot", rd_slot, 5);
    if (wlog.size() == 3) check("rw_rd_after_w", rd_cyc, wlog[2].c + 1);
    check("rw_valid_count", valid_cnt - v0, 1);
    check("rw_valid_cycle", valid_cyc, t0 + 5);
    check("rw_rd_data", valid_data, 32'hD000_0005);
    check("rw_hold", mmio_rd_data, 32'hD000_0005);
    // reset asserted while a read of slot 3 is in flight
    @(posedge clk); #1;
    v0 = valid_cnt; r0 = rd_cnt;
    do_acc(0, 1, 21'h60, 32'h0, t);
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    idle_check("rst_mid");
    repeat (5) @(negedge clk);
    check("rst_mid_no_valid", valid_cnt - v0, 0);
    check("rst_mid_no_rd", rd_cnt - r0, 0);
    // unmapped read: slot 63, upper address bits set
    @(posedge clk); #1;
    v0 = valid_cnt; r0 = rd_cnt;
    do_acc(0, 1, 21'h0A07E3, 32'h0, t);
    repeat (5) @(negedge clk);
    check("unm_rd_no_strobe", rd_cnt - r0, 0);
    check("unm_rd_valid_cycle", valid_cyc, t + 2);
    check("unm_rd_data", valid_data, 0);
`ifdef MMIO_ERR_CAPTURE_EN
    check("err_flag_set", err_flag, 1);
    check("err_addr_cap", err_addr, 21'h0A07E3);
`endif
    // unmapped write: slot 20
    @(posedge clk); #1;
    wlog.delete();
    do_acc(1, 0, 21'h281, 32'hDEAD_0000, t);
    repeat (3) @(negedge clk);
    check("unm_wr_no_strobe", wlog.size(), 0);
`ifdef MMIO_ERR_CAPTURE_EN
    check("err_addr_keep", err_addr, 21'h0A07E3);
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    check("err_clr_flag", err_flag, 0);
    check("err_clr_addr", err_addr, 0);
    do_acc(1, 0, 21'h281, 32'h0, t);
    err_clr = 1;
    do_acc(1, 0, 21'h2A1, 32'h0, t);
    err_clr = 0;
    check("err_clr_new_wins_flag", err_flag, 1);
    check("err_clr_new_wins_addr", err_addr, 21'h2A1);
`endif
    // simultaneous write and read to slot 1 reg 4
    @(posedge clk); #1;
    wlog.delete();
    v0 = valid_cnt; r0 = rd_cnt;
    do_acc(1, 1, 21'h24, 32'h0000_BEEF, t);
    repeat (5) @(negedge clk);
    check("wr_rd_wcount", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check("wr_rd_slot", wlog[0].slot, 1);
      check("wr_rd_data", wlog[0].d, 32'h0000_BEEF);
    end
    check("wr_rd_no_rd", rd_cnt - r0, 0);
    check("wr_rd_no_valid", valid_cnt - v0, 0);
    check("strobe_onehot", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_slot_fabric.md
Name: mmio_slot_fabric

Overview:
- Parametrised successor to the FPro MMIO slot controller.
- Decodes bus accesses into NUM_SLOTS I/O slots and adds a posted-write buffer, so CPU writes never wait on a slot.
- Reads are strictly ordered behind buffered writes and answered through a ready/valid handshake.
- Sits between the FPro bus and the per-slot cores in each mmio_sys top level.

Parameters:
- NUM_SLOTS, 64: number of slots decoded, 1..64.
- SLOT_BITS, 6: slot-index field width; must satisfy 2**SLOT_BITS >= NUM_SLOTS.
- REG_BITS, 5: per-slot register-address width.
- WBUF_DEPTH, 4: posted-write FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mmio_cs  in  1  bus select
- mmio_wr  in  1  write request
- mmio_rd  in  1  read request
- mmio_addr  in  21  word address
- mmio_wr_data  in  32  write data
- mmio_ready  out  1  request accepted this cycle when high
- mmio_rd_data  out  32  registered read data
- mmio_rd_valid  out  1  one-cycle pulse: mmio_rd_data is new
- slot_cs_array  out  NUM_SLOTS  one-hot slot select
- slot_mem_rd_array  out  NUM_SLOTS  one-hot read strobe
- slot_mem_wr_array  out  NUM_SLOTS  one-hot write strobe
- slot_reg_addr  out  REG_BITS  register address, shared by all slots
- slot_wr_data  out  32  write data, shared by all slots
- slot_rd_data_flat  in  32*NUM_SLOTS  slot i read data at bits [32*i+31:32*i]

Behaviour:
- Decode:
  - slot = mmio_addr[REG_BITS+SLOT_BITS-1:REG_BITS]; reg = mmio_addr[REG_BITS-1:0]; upper address bits ignored.
  - A slot index >= NUM_SLOTS is unmapped: a write is accepted and discarded with no strobe; a read returns 32'h0.
- Handshake:
  - accept = mmio_cs & (mmio_wr | mmio_rd) & mmio_ready.
  - mmio_ready = (state==IDLE) & ~wbuf_full.
  - If mmio_wr and mmio_rd are both high, the access is a write.
  - The host holds its request until accepted.
- Write path:
  - An accepted write pushes {slot, reg, data} into the FIFO.
  - The head entry drains when the FIFO is non-empty and state != ISSUE: one entry per cycle, one cycle of cs+wr to its slot.
  - A write accepted at edge T reaches the slot no earlier than cycle T+1.
  - Push and pop in the same cycle leave the count unchanged.
  - Full: mmio_ready stays low until a pop occurs.
- FSM states IDLE, DRAIN, ISSUE, RESP:
  - IDLE, read accepted: go to DRAIN if the FIFO is non-empty after this cycle's pop, else ISSUE. The read address is latched.
  - DRAIN: go to ISSUE once the FIFO is empty.
  - ISSUE: drive cs+rd to the latched slot for exactly one cycle; mmio_rd_data <= the selected slot's data (0 if unmapped) at the end of the cycle.
  - RESP: mmio_rd_valid = 1 for one cycle; then IDLE.
- Read latency with an empty FIFO: accepted at edge T, mmio_rd_valid high in cycle T+2. Each buffered write ahead of the read adds one cycle.
- mmio_rd_data holds its value until the next ISSUE.
- At most one strobe bit is high across all slot arrays in any cycle.
- slot_reg_addr and slot_wr_data are don't-care when no strobe is active.
- Reset (async assert, sync deassert expected):
  - FIFO flushed; pending writes are lost; state IDLE.
  - All slot strobes, mmio_rd_valid and mmio_rd_data are 0.
  - mmio_ready = 1 on the first cycle after release.
  - Reset mid-read: no mmio_rd_valid is produced for that read.

Optional Feature:
- MMIO_ERR_CAPTURE_EN defined:
  - Adds outputs err_flag (1) and err_addr (21), plus input err_clr (1).
  - On the first unmapped access (read or write) while err_flag=0, capture mmio_addr and set err_flag.
  - Later errors do not overwrite the captured address.
  - err_clr=1 clears both; if err_clr coincides with a new error, the new error wins.
  - Reset clears both.
- Undefined: the ports are absent and unmapped accesses are silently dropped or read as 0.

Test Plan:
- Reset low mid-run, then high -> all strobes 0, mmio_rd_data=0, mmio_ready=1 on the first cycle after release.
- Write 32'hA5A5_0001 to slot 2, reg 3, FIFO empty -> slot_mem_wr_array[2] high for one cycle at T+1 with slot_reg_addr=3.
- 5 back-to-back writes, WBUF_DEPTH=4, no drain stalls -> all 5 accepted with mmio_ready never low; slots see the writes in order.
- 3 writes to slot 5, then a read of slot 5 -> read strobe only after the 3rd write strobe; mmio_rd_valid at T+2+3 with the slot's data.
- Read of slot index 63 with NUM_SLOTS=14 -> no strobe; mmio_rd_data=0 at T+2; with MMIO_ERR_CAPTURE_EN, err_flag=1 and err_addr equals the address.
- Simultaneous mmio_wr and mmio_rd to slot 1 -> write strobe only, no mmio_rd_valid.
